core_fetch_decode_top: RTL and testbench

RV32I core front end: instruction/data memory load ports, program counter, synchronous instruction memory, and a registered RV32I decoder. Decoded fields and operation classes are exposed for the core-level bench. The bench preloads the program through the write port, then asserts iStart. Execution is out of scope: PC advances sequentially; branch/jump targets are not applied.

---
 rtl/core_fetch_decode_top.sv | 275 +++++++++++++++++++++++++++
 tb/tb_core_fetch_decode_top.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_decode_top.sv
// ---------------------------------------------------------------------------
// core_fetch_decode_top
// RV32I front end: program/data load ports, sequential program counter,
// synchronous instruction memory and a registered RV32I decoder.
//
// Ports
//   iClk, iRst            clock, asynchronous active-low reset
//   iStart                level; first high after reset starts fetching
//   iInst2Write/iInstWen  instruction load port (auto-incrementing pointer)
//   iData2Write/iDataWen  data load port (auto-incrementing pointer)
//   oRs1Addr..oOpcode     raw instruction fields of the decoded instruction
//   oImm                  sign-extended immediate for the decoded format
//   oCurPc                byte address of the decoded instruction
//   oLoad/oStore/oMemDv   memory operation class
//   oAritType, oOp*       ALU operation and operand selectors
//   oBrOp/oBrDv           branch/jump class
// ---------------------------------------------------------------------------
module core_fetch_decode_top #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStart,
  input  logic [XLEN-1:0] iInst2Write,
  input  logic            iInstWen,
  input  logic [XLEN-1:0] iData2Write,
  input  logic            iDataWen,
  output logic [4:0]      oRs1Addr,
  output logic [4:0]      oRs2Addr,
  output logic [4:0]      oRdAddr,
  output logic [2:0]      oF3,
  output logic [6:0]      oF7,
  output logic [XLEN-1:0] oImm,
  output logic [6:0]      oOpcode,
  output logic [XLEN-1:0] oCurPc,
  output logic [4:0]      oLoad,
  output logic [2:0]      oStore,
  output logic            oMemDv,
  output logic [3:0]      oAritType,
  output logic            oOpRs1,
  output logic            oOpRs2,
  output logic            oOpImm,
  output logic            oOpPc,
  output logic            oOpConst,
  output logic            oOpDv,
  output logic [2:0]      oBrOp,
  output logic            oBrDv
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_DEPTH * 4 - 1);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OPIMM  = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_e;

  typedef enum logic [3:0] {
    AR_ADD = 4'd0, AR_SUB = 4'd1, AR_SLL = 4'd2, AR_SLT = 4'd3, AR_SLTU = 4'd4,
    AR_XOR = 4'd5, AR_SRL = 4'd6, AR_SRA = 4'd7, AR_OR  = 4'd8, AR_AND  = 4'd9
  } arit_e;

  // f7[5] selects SUB only for register-register ops; it always selects SRA.
  function automatic arit_e arit_of(input logic [2:0] f3, input logic f7_5,
                                    input logic allow_sub);
    case (f3)
      3'd0:    arit_of = (allow_sub && f7_5) ? AR_SUB : AR_ADD;
      3'd1:    arit_of = AR_SLL;
      3'd2:    arit_of = AR_SLT;
      3'd3:    arit_of = AR_SLTU;
      3'd4:    arit_of = AR_XOR;
      3'd5:    arit_of = f7_5 ? AR_SRA : AR_SRL;
      3'd6:    arit_of = AR_OR;
      default: arit_of = AR_AND;
    endcase
  endfunction

  logic [XLEN-1:0] r_imem [IMEM_DEPTH];
  logic [XLEN-1:0] r_dmem [DMEM_DEPTH];
  logic [IW-1:0]   r_inst_wptr;
  logic [DW-1:0]   r_data_wptr;
  logic            r_run;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_fetch_valid;
  logic [XLEN-1:0] r_inst;

  // NOTE: memory arrays and their read register have no reset: contents must
  // survive iRst, and a reset would turn the arrays into flop banks.
  always_ff @(posedge iClk) begin
    if (iInstWen) r_imem[r_inst_wptr] <= iInst2Write;
    if (iDataWen) r_dmem[r_data_wptr] <= iData2Write;
    if (r_run)    r_inst <= r_imem[r_pc[IW+1:2]];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_inst_wptr   <= '0;
      r_data_wptr   <= '0;
      r_run         <= 1'b0;
      r_pc          <= '0;
      r_fetch_pc    <= '0;
      r_fetch_valid <= 1'b0;
    end else begin
      if (iInstWen)
        r_inst_wptr <= (r_inst_wptr == IW'(IMEM_DEPTH - 1)) ? '0 : r_inst_wptr + IW'(1);
      if (iDataWen)
        r_data_wptr <= (r_data_wptr == DW'(DMEM_DEPTH - 1)) ? '0 : r_data_wptr + DW'(1);
      if (iStart) r_run <= 1'b1;
      // r_inst becomes valid one edge after a running edge.
      r_fetch_valid <= r_run;
      if (r_run) begin
        r_fetch_pc <= r_pc;
        r_pc       <= (r_pc + XLEN'(4)) & PC_MASK;
      end
    end
  end

  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_load;
  logic [2:0]      w_store;
  logic            w_mem_dv;
  arit_e           w_arit;
  logic            w_op_rs1, w_op_rs2, w_op_imm, w_op_pc, w_op_const, w_op_dv;
  logic [2:0]      w_br_op;
  logic            w_br_dv;

  assign w_f3 = r_inst[14:12];
  assign w_f7 = r_inst[31:25];

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_imm      = '0;
    w_load     = '0;
    w_store    = '0;
    w_mem_dv   = 1'b0;
    w_arit     = AR_ADD;
    w_op_rs1   = 1'b0;
    w_op_rs2   = 1'b0;
    w_op_imm   = 1'b0;
    w_op_pc    = 1'b0;
    w_op_const = 1'b0;
    w_op_dv    = 1'b0;
    w_br_op    = '0;
    w_br_dv    = 1'b0;
    case (r_inst[6:0])
      OPC_OP: begin
        w_arit   = arit_of(w_f3, w_f7[5], 1'b1);
        w_op_rs1 = 1'b1;
        w_op_rs2 = 1'b1;
        w_op_dv  = 1'b1;
      end
      OPC_OPIMM: begin
        w_imm    = {{20{r_inst[31]}}, r_inst[31:20]};
        w_arit   = arit_of(w_f3, w_f7[5], 1'b0);
        w_op_rs1 = 1'b1;
        w_op_imm = 1'b1;
        w_op_dv  = 1'b1;
      end
      OPC_LUI: begin
        w_imm    = {r_inst[31:12], 12'b0};
        w_op_imm = 1'b1;
        w_op_dv  = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm    = {r_inst[31:12], 12'b0};
        w_op_pc  = 1'b1;
        w_op_imm = 1'b1;
        w_op_dv  = 1'b1;
      end
      OPC_JAL: begin
        w_imm      = {{12{r_inst[31]}}, r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
        w_op_pc    = 1'b1;
        w_op_const = 1'b1;
        w_op_dv    = 1'b1;
        w_br_op    = 3'd2;
        w_br_dv    = 1'b1;
      end
      OPC_JALR: begin
        w_imm      = {{20{r_inst[31]}}, r_inst[31:20]};
        w_op_pc    = 1'b1;
        w_op_const = 1'b1;
        w_op_dv    = 1'b1;
        w_br_op    = 3'd3;
        w_br_dv    = 1'b1;
      end
      OPC_LOAD: begin
        w_imm = {{20{r_inst[31]}}, r_inst[31:20]};
        case (w_f3)
          3'd0:    w_load = 5'b00001;
          3'd1:    w_load = 5'b00010;
          3'd2:    w_load = 5'b00100;
          3'd4:    w_load = 5'b01000;
          3'd5:    w_load = 5'b10000;
          default: w_load = 5'b00000;
        endcase
        w_mem_dv = |w_load;
      end
      OPC_STORE: begin
        w_imm = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
        case (w_f3)
          3'd0:    w_store = 3'b001;
          3'd1:    w_store = 3'b010;
          3'd2:    w_store = 3'b100;
          default: w_store = 3'b000;
        endcase
        w_mem_dv = |w_store;
      end
      OPC_BRANCH: begin
        w_imm = {{20{r_inst[31]}}, r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
        // funct3 2 and 3 are not branches; leave class outputs at zero.
        if (w_f3 != 3'd2 && w_f3 != 3'd3) begin
          w_br_op = w_f3;
          w_br_dv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Decode register: loads on every valid fetch; otherwise only the valid
  // flags drop and the field outputs hold.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oRs1Addr <= '0; oRs2Addr <= '0; oRdAddr <= '0; oF3 <= '0; oF7 <= '0;
      oImm     <= '0; oOpcode  <= '0; oCurPc  <= '0;
      oLoad    <= '0; oStore   <= '0; oMemDv  <= 1'b0;
      oAritType <= '0;
      oOpRs1   <= 1'b0; oOpRs2 <= 1'b0; oOpImm <= 1'b0; oOpPc <= 1'b0;
      oOpConst <= 1'b0; oOpDv  <= 1'b0;
      oBrOp    <= '0; oBrDv <= 1'b0;
    end else if (r_fetch_valid) begin
      oRs1Addr  <= r_inst[19:15];
      oRs2Addr  <= r_inst[24:20];
      oRdAddr   <= r_inst[11:7];
      oF3       <= w_f3;
      oF7       <= w_f7;
      oImm      <= w_imm;
      oOpcode   <= r_inst[6:0];
      oCurPc    <= r_fetch_pc;
      oLoad     <= w_load;
      oStore    <= w_store;
      oMemDv    <= w_mem_dv;
      oAritType <= w_arit;
      oOpRs1    <= w_op_rs1;
      oOpRs2    <= w_op_rs2;
      oOpImm    <= w_op_imm;
      oOpPc     <= w_op_pc;
      oOpConst  <= w_op_const;
      oOpDv     <= w_op_dv;
      oBrOp     <= w_br_op;
      oBrDv     <= w_br_dv;
    end else begin
      oMemDv <= 1'b0;
      oOpDv  <= 1'b0;
      oBrDv  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_fetch_decode_top.sv
// ---------------------------------------------------------------------------
// tb_core_fetch_decode_top
// Directed bench for core_fetch_decode_top: loads a short RV32I program,
// starts fetching, and compares every decoded output against hand-computed
// values, including reset behaviour, restart after reset and PC wrap.
// ---------------------------------------------------------------------------
module tb_core_fetch_decode_top;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [31:0] iInst2Write;
  logic        iInstWen;
  logic [31:0] iData2Write;
  logic        iDataWen;
  logic [4:0]  oRs1Addr, oRs2Addr, oRdAddr;
  logic [2:0]  oF3;
  logic [6:0]  oF7;
  logic [31:0] oImm;
  logic [6:0]  oOpcode;
  logic [31:0] oCurPc;
  logic [4:0]  oLoad;
  logic [2:0]  oStore;
  logic        oMemDv;
  logic [3:0]  oAritType;
  logic        oOpRs1, oOpRs2, oOpImm, oOpPc, oOpConst, oOpDv;
  logic [2:0]  oBrOp;
  logic        oBrDv;

  int n_total = 0;
  int n_pass  = 0;

  core_fetch_decode_top dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iInst2Write(iInst2Write), .iInstWen(iInstWen),
    .iData2Write(iData2Write), .iDataWen(iDataWen),
    .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr), .oRdAddr(oRdAddr),
    .oF3(oF3), .oF7(oF7), .oImm(oImm), .oOpcode(oOpcode), .oCurPc(oCurPc),
    .oLoad(oLoad), .oStore(oStore), .oMemDv(oMemDv), .oAritType(oAritType),
    .oOpRs1(oOpRs1), .oOpRs2(oOpRs2), .oOpImm(oOpImm), .oOpPc(oOpPc),
    .oOpConst(oOpConst), .oOpDv(oOpDv), .oBrOp(oBrOp), .oBrDv(oBrDv)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".fields"}, {oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oOpcode}, 32'h0);
    check({tag, ".imm"}, oImm, 32'h0);
    check({tag, ".pc"}, oCurPc, 32'h0);
    check({tag, ".ctrl"}, {9'h0, oLoad, oStore, oMemDv, oAritType, oOpRs1, oOpRs2,
                            oOpImm, oOpPc, oOpConst, oOpDv, oBrOp, oBrDv}, 32'h0);
  endtask

  task automatic check_dv_zero(input string tag);
    check({tag, ".dv"}, {29'h0, oMemDv, oOpDv, oBrDv}, 32'h0);
  endtask

  // ops = {rs1, rs2, imm, pc, const}
  task automatic expect_dec(input string tag,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [6:0] opc,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic [4:0] ld, input logic [2:0] st,
                            input logic mdv, input logic [3:0] arit,
                            input logic [4:0] ops, input logic odv,
                            input logic [2:0] brop, input logic brdv);
    check({tag, ".rs1"}, 32'(oRs1Addr), 32'(rs1));
    check({tag, ".rs2"}, 32'(oRs2Addr), 32'(rs2));
    check({tag, ".rd"}, 32'(oRdAddr), 32'(rd));
    check({tag, ".f3"}, 32'(oF3), 32'(f3));
    check({tag, ".f7"}, 32'(oF7), 32'(f7));
    check({tag, ".opcode"}, 32'(oOpcode), 32'(opc));
    check({tag, ".imm"}, oImm, imm);
    check({tag, ".pc"}, oCurPc, pc);
    check({tag, ".load"}, 32'(oLoad), 32'(ld));
    check({tag, ".store"}, 32'(oStore), 32'(st));
    check({tag, ".memdv"}, 32'(oMemDv), 32'(mdv));
    check({tag, ".arit"}, 32'(oAritType), 32'(arit));
    check({tag, ".ops"}, 32'({oOpRs1, oOpRs2, oOpImm, oOpPc, oOpConst}), 32'(ops));
    check({tag, ".opdv"}, 32'(oOpDv), 32'(odv));
    check({tag, ".brop"}, 32'(oBrOp), 32'(brop));
    check({tag, ".brdv"}, 32'(oBrDv), 32'(brdv));
  endtask

  logic [31:0] prog [8];

  initial begin
    prog[0] = 32'h00500093;  // addi x1,x0,5
    prog[1] = 32'h402081B3;  // sub  x3,x1,x2
    prog[2] = 32'h00112223;  // sw   x1,4(x2)
    prog[3] = 32'h123452B7;  // lui  x5,0x12345
    prog[4] = 32'hFE000EE3;  // beq  x0,x0,-4
    prog[5] = 32'h0040A103;  // lw   x2,4(x1)
    prog[6] = 32'h008000EF;  // jal  x1,8
    prog[7] = 32'h0000000B;  // custom-0: unknown opcode

    iRst = 1'b0; iStart = 1'b0;
    iInst2Write = '0; iInstWen = 1'b0; iData2Write = '0; iDataWen = 1'b0;
    step(); step();
    check_all_zero("reset");

    iRst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iInst2Write = prog[i]; iInstWen = 1'b1;
      iData2Write = 32'hD000_0000 + 32'(i); iDataWen = 1'b1;
      step();
    end
    iInstWen = 1'b0; iDataWen = 1'b0;
    repeat (6) step();
    check_dv_zero("idle");
    check_all_zero("idle_hold");

    // iStart for a single cycle; the run flag keeps fetching afterwards.
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    check_dv_zero("lat0");
    step();
    check_dv_zero("lat1");
    step();
    expect_dec("addi", 5'd0, 5'd5, 5'd1, 3'd0, 7'h00, 7'h13, 32'd5, 32'd0,
               5'b0, 3'b0, 1'b0, 4'd0, 5'b10100, 1'b1, 3'd0, 1'b0);
    step();
    expect_dec("sub", 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 7'h33, 32'd0, 32'd4,
               5'b0, 3'b0, 1'b0, 4'd1, 5'b11000, 1'b1, 3'd0, 1'b0);
    step();
    expect_dec("sw", 5'd2, 5'd1, 5'd4, 3'd2, 7'h00, 7'h23, 32'd4, 32'd8,
               5'b0, 3'b100, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0);
    step();
    expect_dec("lui", 5'd8, 5'd3, 5'd5, 3'd5, 7'h09, 7'h37, 32'h12345000, 32'd12,
               5'b0, 3'b0, 1'b0, 4'd0, 5'b00100, 1'b1, 3'd0, 1'b0);
    step();
    expect_dec("beq", 5'd0, 5'd0, 5'd29, 3'd0, 7'h7F, 7'h63, 32'hFFFFFFFC, 32'd16,
               5'b0, 3'b0, 1'b0, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b1);
    step();
    expect_dec("lw", 5'd1, 5'd4, 5'd2, 3'd2, 7'h00, 7'h03, 32'd4, 32'd20,
               5'b00100, 3'b0, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0);
    step();
    expect_dec("jal", 5'd0, 5'd8, 5'd1, 3'd0, 7'h00, 7'h6F, 32'd8, 32'd24,
               5'b0, 3'b0, 1'b0, 4'd0, 5'b00011, 1'b1, 3'd2, 1'b1);
    step();
    expect_dec("unknown", 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h0B, 32'd0, 32'd28,
               5'b0, 3'b0, 1'b0, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0);

    // Asynchronous reset mid-run: outputs clear before any clock edge.
    #2;
    iRst = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    iRst = 1'b1;
    repeat (3) step();
    check_dv_zero("rerun_idle");

    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step();
    step();
    expect_dec("rerun_addi", 5'd0, 5'd5, 5'd1, 3'd0, 7'h00, 7'h13, 32'd5, 32'd0,
               5'b0, 3'b0, 1'b0, 4'd0, 5'b10100, 1'b1, 3'd0, 1'b0);

    // 1024 instructions later the PC has wrapped back to word 0.
    repeat (1024) step();
    check("wrap.pc", oCurPc, 32'd0);
    check("wrap.opcode", 32'(oOpcode), 32'h13);
    check("wrap.opdv", 32'(oOpDv), 32'd1);
    check("wrap.imm", oImm, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
